// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : mem_arb_pkg                                                 |
// | Purpose    : Shared types and helpers for mem_bus_arbiter: FSM state     |
// |              encoding, burst codes, burst-length decode and the default  |
// |              stall timeout.                                              |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_TURN  = 3'd2,
    ST_XFER  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  localparam logic [1:0] BURST_1  = 2'b00;
  localparam logic [1:0] BURST_4  = 2'b01;
  localparam logic [1:0] BURST_8  = 2'b10;
  localparam logic [1:0] BURST_16 = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Burst code -> index of the last beat (beats - 1), fits the 4-bit counter.
  function automatic logic [3:0] burst_last(input logic [1:0] code);
    logic [3:0] r;
    case (code)
      BURST_1:  r = 4'd0;
      BURST_4:  r = 4'd3;
      BURST_8:  r = 4'd7;
      BURST_16: r = 4'd15;
      default:  r = 4'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : mem_bus_arbiter_if                                          |
// | Purpose    : Bundles the requester side (m_*) and the cellular-RAM       |
// |              controller side (b*) of the bus arbiter.                    |
// | Modports   : slave  - arbiter view (requests and controller status in,   |
// |                       grants, strobes and steered data out)              |
// |              master - environment view (masters + controller)            |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]    m_req;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [16*NUM_MASTERS-1:0] m_addr;
  logic [2*NUM_MASTERS-1:0]  m_burst;
  logic [16*NUM_MASTERS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]    m_wnext;
  logic [15:0]               m_rdata;
  logic [NUM_MASTERS-1:0]    m_rvalid;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_err;
  logic [NUM_MASTERS-1:0]    grant;
  logic [15:0]               baddr;
  logic [1:0]                bburst;
  logic                      bwe;
  logic                      bstart;
  logic [15:0]               bwdata;
  logic                      bdata_oe;
  logic [15:0]               brdata;
  logic                      bwait;

  modport slave (
    input  m_req, m_we, m_addr, m_burst, m_wdata, brdata, bwait,
    output m_wnext, m_rdata, m_rvalid, m_ack, m_err, grant,
           baddr, bburst, bwe, bstart, bwdata, bdata_oe
  );

  modport master (
    output m_req, m_we, m_addr, m_burst, m_wdata, brdata, bwait,
    input  m_wnext, m_rdata, m_rvalid, m_ack, m_err, grant,
           baddr, bburst, bwe, bstart, bwdata, bdata_oe
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : rr_picker                                                   |
// | Purpose    : Combinational round-robin selector. Picks the first set     |
// |              bit of req searching upward from last+1 (mod NUM_MASTERS).  |
// | Ports      : req       in  request vector                                |
// |              last      in  index of the most recently served master      |
// |              gnt       out one-hot winner (zero if no request)           |
// |              gnt_idx   out binary index of the winner                    |
// |              gnt_valid out any request present                           |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IW-1:0]          gnt_idx,
  output logic                   gnt_valid
);

  // Outer loop walks priority distance from last+1; the first match locks out
  // every later candidate, so the nearest requester after last wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!gnt_valid && req[i] &&
            (((i + NUM_MASTERS - 1 - int'(last)) % NUM_MASTERS) == k)) begin
          gnt_valid = 1'b1;
          gnt[i]    = 1'b1;
          gnt_idx   = IW'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mem_bus_arbiter                                             |
// | Purpose    : Round-robin arbiter sharing the cellular-RAM controller     |
// |              bus port among NUM_MASTERS requesters. Latches one request, |
// |              strobes bstart, steers burst beats, acks and rotates.       |
// | Ports      : clk50MHz  in  system clock                                  |
// |              rst       in  asynchronous active-high reset                |
// |              bus       mem_bus_arbiter_if.slave (m_* masters, b* ctrl)   |
// | Options    : MEM_ARB_TIMEOUT_EN - abort XFER after TIMEOUT_CYCLES        |
// |              consecutive bwait cycles, pulsing m_err with m_ack.         |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk50MHz,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [15:0]            baddr_q, baddr_d;
  logic [1:0]             bburst_q, bburst_d;
  logic                   bwe_q, bwe_d;
  logic                   bstart_q, bstart_d;
  logic [3:0]             beat_q, beat_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   beat_ok;
  logic                   last_beat;
  logic                   to_hit;

  // Per-master views of the packed request fields.
  logic [15:0] addr_arr  [NUM_MASTERS];
  logic [1:0]  burst_arr [NUM_MASTERS];
  logic [15:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = bus.m_addr[16*i +: 16];
    assign burst_arr[i] = bus.m_burst[2*i +: 2];
    assign wdata_arr[i] = bus.m_wdata[16*i +: 16];
  end

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_rr_picker (
    .req       (bus.m_req),
    .last      (last_q),
    .gnt       (pick_onehot),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign beat_ok   = (state_q == ST_XFER) && !bus.bwait;
  assign last_beat = beat_ok && (beat_q == burst_last(bburst_q));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts consecutive stalled XFER cycles; any beat or other state clears it.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ST_XFER) && bus.bwait) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit = (state_q == ST_XFER) && bus.bwait &&
                  (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    baddr_d  = baddr_q;
    bburst_d = bburst_q;
    bwe_d    = bwe_q;
    beat_d   = beat_q;
    bstart_d = 1'b0;
    ack_d    = '0;
    err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_ISSUE;
          grant_d  = pick_onehot;
          gidx_d   = pick_idx;
          baddr_d  = addr_arr[pick_idx];
          bburst_d = burst_arr[pick_idx];
          bwe_d    = bus.m_we[pick_idx];
          bstart_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_TURN;
        beat_d  = 4'd0;
      end
      ST_TURN: begin
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (last_beat) begin
          state_d = ST_DONE;
          ack_d   = grant_q;
        end else if (beat_ok) begin
          beat_d = beat_q + 4'd1;
        end else if (to_hit) begin
          state_d = ST_DONE;
          ack_d   = grant_q;
          err_d   = grant_q;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        last_d   = gidx_q;
        baddr_d  = '0;
        bburst_d = '0;
        bwe_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= IW'(NUM_MASTERS - 1);
      baddr_q  <= '0;
      bburst_q <= '0;
      bwe_q    <= 1'b0;
      beat_q   <= '0;
      bstart_q <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      baddr_q  <= baddr_d;
      bburst_q <= bburst_d;
      bwe_q    <= bwe_d;
      beat_q   <= beat_d;
      bstart_q <= bstart_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.m_ack    = ack_q;
  assign bus.m_err    = err_q;
  assign bus.baddr    = baddr_q;
  assign bus.bburst   = bburst_q;
  assign bus.bwe      = bwe_q;
  assign bus.bstart   = bstart_q;
  assign bus.bdata_oe = bwe_q && ((state_q == ST_ISSUE) ||
                                  (state_q == ST_TURN)  ||
                                  (state_q == ST_XFER));
  // Write data follows the granted master live so it can advance on m_wnext.
  assign bus.bwdata   = bus.bdata_oe ? wdata_arr[gidx_q] : 16'h0000;
  assign bus.m_wnext  = (beat_ok && bwe_q)  ? grant_q : '0;
  assign bus.m_rvalid = (beat_ok && !bwe_q) ? grant_q : '0;
  assign bus.m_rdata  = (beat_ok && !bwe_q) ? bus.brdata : 16'h0000;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares the single bus port of the Micron cellular-RAM controller among `NUM_MASTERS` requesters (CPU fetch, CPU data, video scan-out, DMA). It sits between the masters and the controller's `baddr/bdata/bburst/bwait` port. It latches one request at a time, issues a start strobe, and steers burst beats back to the granted master. It then acknowledges the request and rotates priority.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 64: consecutive `bwait`-high cycles before abort (only with timeout macro).

Ports (N = `NUM_MASTERS`):
- `clk50MHz`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_req`  in  N  request per master; held until `m_ack`.
- `m_we`  in  N  1 = write, 0 = read.
- `m_addr`  in  16·N  start word address, packed master i at [16i+15:16i].
- `m_burst`  in  2·N  burst code: 00=1, 01=4, 10=8, 11=16 words.
- `m_wdata`  in  16·N  write word for the current beat.
- `m_wnext`  out  N  one-cycle pulse: write beat accepted, present next word.
- `m_rdata`  out  16  read word, shared by all masters.
- `m_rvalid`  out  N  one-cycle pulse: `m_rdata` valid for that master.
- `m_ack`  out  N  one-cycle pulse: request complete.
- `m_err`  out  N  pulse coincident with `m_ack` on timeout abort.
- `grant`  out  N  one-hot owner, zero when idle.
- `baddr`, `bburst`, `bwe`  out  16/2/1  latched request fields to controller.
- `bstart`  out  1  one-cycle transaction start strobe.
- `bwdata`  out  16, `bdata_oe` out 1  write data and tristate enable (tristate at top level).
- `brdata`  in  16  read data from controller.
- `bwait`  in  1  controller stall; beat transfers when low.

## Operation
- States: IDLE → ISSUE → TURN → XFER → DONE → IDLE.
- IDLE: the `rr_picker` selects the first asserted `m_req` starting at `last+1` (mod N). It latches `m_addr`, `m_we`, `m_burst` and sets `grant`.
- ISSUE: `bstart`=1 for one cycle. `baddr`, `bburst`, `bwe` stay stable from ISSUE through DONE.
- TURN: one cycle. `bwait` is ignored (controller turnaround).
- XFER: in each cycle with `bwait`=0 one beat completes.
  - Read: `m_rdata`=`brdata`, `m_rvalid[g]`=1.
  - Write: `bwdata`=`m_wdata[g]` (combinational from the granted master), `m_wnext[g]`=1.
  - A 4-bit beat counter counts up to length−1. After the last beat the FSM enters DONE.
- DONE: `m_ack[g]`=1, `last`←g. `grant` clears on entry to IDLE.
- `bdata_oe` = latched `we` AND state ∈ {ISSUE, TURN, XFER}.
- A master keeping `m_req` high after `m_ack` is treated as a new request and loses priority to every other pending master.
- Changes to `m_req` or fields of non-granted masters have no effect. Dropping `m_req` of the granted master mid-transaction is ignored; the transaction completes.

## Timing
- Reset values: all outputs 0, state IDLE, `last`=N−1 (master 0 wins first).
- Reset asserted mid-transaction aborts immediately. No `m_ack` is issued; the master must re-request.
- Request sampled in IDLE at cycle T:
  - `grant`/`bstart` at T+1.
  - First beat no earlier than T+3.
  - `m_ack` one cycle after the last beat.
- Minimum single-word latency: req T → ack T+4.
- Zero-stall burst of L beats: ack at T+3+L.
- Back-to-back grants: one IDLE cycle between DONE and the next ISSUE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter counts consecutive `bwait`=1 cycles in XFER and resets on any beat.
  - Reaching `TIMEOUT_CYCLES` forces DONE with `m_ack[g]` and `m_err[g]` both pulsed.
- Undefined: no counter, `m_err` tied 0, and XFER waits indefinitely.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding constants.
  - Burst-code constants and the burst-length function (code → beats−1).
  - Default `TIMEOUT_CYCLES`.
- Sub-module `rr_picker`: combinational round-robin one-hot selector taking `req` and `last`.

## Test plan
- Reset, then master 1 reads burst 00 at 0x0123, `bwait` high 3 cycles after TURN, `brdata`=0xBEEF → `bstart` with `baddr`=0x0123, one `m_rvalid[1]` with 0xBEEF, `m_ack[1]` after it.
- All four masters request reads simultaneously after reset → grants in order 0,1,2,3, each with a single `bstart` and `m_ack`.
- Master 2 writes burst 01 with `bwait`=0 throughout, `m_wdata` advancing 0x0001..0x0004 on `m_wnext` → 4 consecutive `m_wnext[2]`, `bwdata` sequence 1,2,3,4, `bdata_oe` high ISSUE..XFER, `m_ack[2]` at T+7.
- Master 0 holds `m_req` continuously while master 2 requests once → grant order 0,2,0.
- `rst` pulsed during beat 3 of a 16-beat read → all outputs 0 within the same cycle, no `m_ack`; next grant goes to master 0.
- With `MEM_ARB_TIMEOUT_EN`, `bwait` stuck high → `m_ack` and `m_err` pulse after 64 stall cycles, then the next pending master is granted. Without the macro the bench observes no `m_ack`.
